// File: rtl/altr_hps_rst_seq_pkg.sv
// Shared state encoding and width helper for the HPS reset sequencer.
package altr_hps_rst_seq_pkg;

    localparam logic [1:0] S_CNT  = 2'd0;
    localparam logic [1:0] S_DONE = 2'd1;
    localparam logic [1:0] S_WARM = 2'd2;

    // Smallest unsigned width able to represent value (never below 1).
    function automatic int bits_for(input int value);
        int w;
        w = 1;
        while ((1 << w) <= value) w++;
        return w;
    endfunction

endpackage

// File: rtl/altr_hps_rst_seq_if.sv
// Request/status bundle between a reset sequencer and its controller.
interface altr_hps_rst_seq_if #(
    parameter int NUM_STG = 4
);
    logic               i_warm_req;
    logic [NUM_STG-1:0] i_stg_hold;
    logic [NUM_STG-1:0] o_stg_rst_n;
    logic               o_seq_done;
    logic               o_warm_ack;

    modport master (
        output i_warm_req, i_stg_hold,
        input  o_stg_rst_n, o_seq_done, o_warm_ack
    );

    modport slave (
        input  i_warm_req, i_stg_hold,
        output o_stg_rst_n, o_seq_done, o_warm_ack
    );
endinterface

// File: rtl/altr_hps_rst_seq_cntr.sv
// Saturating delay counter: sync clear, increment enable, terminal flag at DLY-1.
module altr_hps_rst_seq_cntr #(
    parameter int DLY       = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DLY - 1);

    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == LAST);

endmodule

// File: rtl/altr_hps_rst_seq.sv
// Sequenced per-stage reset release with warm-reset re-assertion.
// Optional: define ALTR_HPS_RST_SEQ_HOLD_EN to let i_stg_hold stall a stage release.
module altr_hps_rst_seq
    import altr_hps_rst_seq_pkg::*;
#(
    parameter int NUM_STG   = 4,
    parameter int DLY       = 8,
    parameter int CNT_WIDTH = bits_for(DLY)
) (
    input logic                 clk,
    input logic                 i_rst,
    altr_hps_rst_seq_if.slave   ifc
);
    localparam int              IDX_W    = bits_for(NUM_STG - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STG - 1);

    logic [1:0]         state;
    logic [IDX_W-1:0]   idx;
    logic [NUM_STG-1:0] stg_rst_n;
    logic               seq_done;
    logic               warm_ack;
    logic               term;
    logic               clr;
    logic               inc;
    logic               rel;
    logic               permit;

`ifdef ALTR_HPS_RST_SEQ_HOLD_EN
    assign permit = ~ifc.i_stg_hold[idx];
`else
    assign permit = 1'b1;
`endif

    altr_hps_rst_seq_cntr #(
        .DLY       (DLY),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cntr (
        .clk  (clk),
        .rst  (i_rst),
        .clr  (clr),
        .inc  (inc),
        .term (term)
    );

    // Warm request outranks a coincident release so no done pulse can slip out.
    always_comb begin
        clr = 1'b0;
        inc = 1'b0;
        rel = 1'b0;
        case (state)
            S_CNT: begin
                if (ifc.i_warm_req) begin
                    clr = 1'b1;
                end else if (term && permit) begin
                    rel = 1'b1;
                    clr = 1'b1;
                end else begin
                    inc = 1'b1;
                end
            end
            S_DONE: begin
                clr = ifc.i_warm_req;
            end
            S_WARM: begin
                if (term) clr = 1'b1;
                else      inc = 1'b1;
            end
            default: clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= S_CNT;
            idx       <= '0;
            stg_rst_n <= '0;
            seq_done  <= 1'b0;
            warm_ack  <= 1'b0;
        end else begin
            warm_ack <= 1'b0;
            case (state)
                S_CNT, S_DONE: begin
                    if (ifc.i_warm_req) begin
                        state     <= S_WARM;
                        idx       <= '0;
                        stg_rst_n <= '0;
                        seq_done  <= 1'b0;
                    end else if (rel) begin
                        stg_rst_n[idx] <= 1'b1;
                        idx            <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= S_DONE;
                            seq_done <= 1'b1;
                        end
                    end
                end
                S_WARM: begin
                    if (term) begin
                        warm_ack <= 1'b1;
                        state    <= S_CNT;
                    end
                end
                default: state <= S_CNT;
            endcase
        end
    end

    assign ifc.o_stg_rst_n = stg_rst_n;
    assign ifc.o_seq_done  = seq_done;
    assign ifc.o_warm_ack  = warm_ack;

endmodule

// File: tb/tb_altr_hps_rst_seq.sv
// Directed bench: DUT a (NUM_STG=4, DLY=8) and DUT b (NUM_STG=3, DLY=1).
module tb_altr_hps_rst_seq;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    altr_hps_rst_seq_if #(.NUM_STG(4)) ifa ();
    altr_hps_rst_seq_if #(.NUM_STG(3)) ifb ();

    altr_hps_rst_seq #(.NUM_STG(4), .DLY(8)) dut_a (
        .clk   (clk),
        .i_rst (rst_a),
        .ifc   (ifa.slave)
    );

    altr_hps_rst_seq #(.NUM_STG(3), .DLY(1)) dut_b (
        .clk   (clk),
        .i_rst (rst_b),
        .ifc   (ifb.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Released-stage mask for n released stages.
    function automatic logic [31:0] rel_mask(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // Check DUT a against the nominal 8-cycle-per-stage release for edges 1..32.
    task automatic run_a_nominal(input string tag);
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk({tag, "_stg"},  32'(ifa.o_stg_rst_n), rel_mask(e / 8));
            chk({tag, "_done"}, 32'(ifa.o_seq_done),  32'(e >= 32));
            chk({tag, "_ack"},  32'(ifa.o_warm_ack),  32'd0);
        end
    endtask

    task automatic warm_a_until_ack(input string tag);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk({tag, "_wstg"}, 32'(ifa.o_stg_rst_n), 32'd0);
            chk({tag, "_wack"}, 32'(ifa.o_warm_ack),  32'(k == 8));
        end
        ifa.i_warm_req = 1'b0;
    endtask

    initial begin
        int exp_n;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.i_warm_req = 1'b0;
        ifa.i_stg_hold = '0;
        ifb.i_warm_req = 1'b0;
        ifb.i_stg_hold = '0;
        tick();
        tick();
        chk("rst_stg",  32'(ifa.o_stg_rst_n), 32'd0);
        chk("rst_done", 32'(ifa.o_seq_done),  32'd0);
        chk("rst_ack",  32'(ifa.o_warm_ack),  32'd0);

        // Nominal release sequence.
        rst_a = 1'b0;
        run_a_nominal("seq");

        // Warm request from S_DONE.
        tick();
        tick();
        chk("done_hold", 32'(ifa.o_stg_rst_n), 32'hF);
        ifa.i_warm_req = 1'b1;
        tick();
        chk("wd_stg",  32'(ifa.o_stg_rst_n), 32'd0);
        chk("wd_done", 32'(ifa.o_seq_done),  32'd0);
        warm_a_until_ack("wd");
        run_a_nominal("wd_re");

        // Warm request mid-sequence: sampled at edge 21.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int e = 1; e <= 20; e++) tick();
        chk("mid_stg20", 32'(ifa.o_stg_rst_n), 32'h3);
        ifa.i_warm_req = 1'b1;
        tick();
        chk("mid_stg21", 32'(ifa.o_stg_rst_n), 32'd0);
        warm_a_until_ack("mid");
        run_a_nominal("mid_re");

        // Reset during S_WARM at cnt=5.
        ifa.i_warm_req = 1'b1;
        tick();
        ifa.i_warm_req = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        rst_a = 1'b1;
        tick();
        chk("wr_stg",  32'(ifa.o_stg_rst_n), 32'd0);
        chk("wr_done", 32'(ifa.o_seq_done),  32'd0);
        chk("wr_ack",  32'(ifa.o_warm_ack),  32'd0);
        rst_a = 1'b0;
        run_a_nominal("wr_re");

        // Stage 2 hold for edges 1..40.
        rst_a = 1'b1;
        ifa.i_stg_hold = 4'b0100;
        tick();
        rst_a = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            if (e == 41) ifa.i_stg_hold = 4'b0000;
            tick();
`ifdef ALTR_HPS_RST_SEQ_HOLD_EN
            exp_n = (e < 8) ? 0 : (e < 16) ? 1 : (e < 41) ? 2 : (e < 49) ? 3 : 4;
`else
            exp_n = (e >= 32) ? 4 : e / 8;
`endif
            chk("hold_stg",  32'(ifa.o_stg_rst_n), rel_mask(exp_n));
            chk("hold_done", 32'(ifa.o_seq_done),  32'(exp_n == 4));
        end

        // Coincident warm request and final release on DUT a.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int e = 1; e <= 31; e++) tick();
        chk("co_stg31", 32'(ifa.o_stg_rst_n), 32'h7);
        ifa.i_warm_req = 1'b1;
        tick();
        chk("co_stg32",  32'(ifa.o_stg_rst_n), 32'd0);
        chk("co_done32", 32'(ifa.o_seq_done),  32'd0);
        ifa.i_warm_req = 1'b0;

        // DUT b: DLY=1, NUM_STG=3.
        chk("b_rst_stg", 32'(ifb.o_stg_rst_n), 32'd0);
        rst_b = 1'b0;
        tick();
        chk("b_e1", 32'(ifb.o_stg_rst_n), 32'h1);
        chk("b_d1", 32'(ifb.o_seq_done),  32'd0);
        tick();
        chk("b_e2", 32'(ifb.o_stg_rst_n), 32'h3);
        tick();
        chk("b_e3", 32'(ifb.o_stg_rst_n), 32'h7);
        chk("b_d3", 32'(ifb.o_seq_done),  32'd1);
        ifb.i_warm_req = 1'b1;
        tick();
        chk("b_w_stg",  32'(ifb.o_stg_rst_n), 32'd0);
        chk("b_w_done", 32'(ifb.o_seq_done),  32'd0);
        chk("b_w_ack0", 32'(ifb.o_warm_ack),  32'd0);
        tick();
        chk("b_w_ack1", 32'(ifb.o_warm_ack),  32'd1);
        ifb.i_warm_req = 1'b0;
        tick();
        chk("b_r1", 32'(ifb.o_stg_rst_n), 32'h1);
        chk("b_r1_ack", 32'(ifb.o_warm_ack), 32'd0);
        tick();
        chk("b_r2", 32'(ifb.o_stg_rst_n), 32'h3);
        ifb.i_warm_req = 1'b1;
        tick();
        chk("b_co_stg",  32'(ifb.o_stg_rst_n), 32'd0);
        chk("b_co_done", 32'(ifb.o_seq_done),  32'd0);
        ifb.i_warm_req = 1'b0;
        tick();
        chk("b_co_ack",   32'(ifb.o_warm_ack), 32'd1);
        chk("b_co_done2", 32'(ifb.o_seq_done), 32'd0);
        tick();
        tick();
        chk("b_re2", 32'(ifb.o_stg_rst_n), 32'h3);
        chk("b_re2_done", 32'(ifb.o_seq_done), 32'd0);
        tick();
        chk("b_re3", 32'(ifb.o_stg_rst_n), 32'h7);
        chk("b_re3_done", 32'(ifb.o_seq_done), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/altr_hps_rst_seq.md
ALTR_HPS_RST_SEQ -- requirements
Module: altr_hps_rst_seq

Interface
REQ-001 Parameter NUM_STG, default 4, number of sequenced reset stages (range 1..16).
REQ-002 Parameter DLY, default 8, cycles between successive stage releases (range 1..2046).
REQ-003 Parameter CNT_WIDTH, default derived from DLY (smallest width holding DLY), counter width.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_warm_req  input  1  level warm-reset request; held until o_warm_ack.
REQ-007 i_stg_hold  input  NUM_STG  per-stage release hold (see Configuration).
REQ-008 o_stg_rst_n  output  NUM_STG  per-stage active-low reset; bit 0 released first.
REQ-009 o_seq_done  output  1  high when all stages are released.
REQ-010 o_warm_ack  output  1  one-cycle pulse ending a warm-reset assertion phase.

Function
REQ-011 FSM states: S_CNT (releasing stages in order), S_DONE (all released), S_WARM (all asserted, timing hold).
REQ-012 All outputs are registered; o_stg_rst_n bits only change on clk edges, never combinationally.
REQ-013 S_CNT, each cycle: if cnt==DLY-1 and release permitted, set o_stg_rst_n[idx], cnt<=0, idx<=idx+1; otherwise cnt<=cnt+1, saturating at DLY-1.
REQ-014 Stage k releases exactly (k+1)*DLY edges after the first edge sampling i_rst=0, absent holds.
REQ-015 Release of stage idx=NUM_STG-1 moves FSM to S_DONE; o_seq_done rises on the same edge as o_stg_rst_n[NUM_STG-1].
REQ-016 Released stages stay released in S_CNT/S_DONE; never more than one bit changes 0->1 per edge.
REQ-017 i_warm_req=1 sampled in S_CNT or S_DONE: next edge all o_stg_rst_n<=0, o_seq_done<=0, cnt<=0, idx<=0, FSM<=S_WARM.
REQ-018 S_WARM: cnt counts 0..DLY-1; at cnt==DLY-1, o_warm_ack<=1 for one cycle, cnt<=0, FSM<=S_CNT.
REQ-019 i_warm_req ignored in S_WARM; if still high the cycle after o_warm_ack, a new warm cycle starts (REQ-017).
REQ-020 Warm request and final-stage release coincident: warm request wins; no o_seq_done pulse occurs.
REQ-021 DLY=1: one stage released per cycle, S_WARM lasts one cycle.

Reset
REQ-022 i_rst=1 at an edge: o_stg_rst_n<=0, o_seq_done<=0, o_warm_ack<=0, cnt<=0, idx<=0, FSM<=S_CNT.
REQ-023 i_rst asserted mid-sequence or mid-warm aborts immediately with REQ-022 values; no o_warm_ack is issued.
REQ-024 First edge with i_rst=0 is count cycle 1 of stage 0.

Configuration
REQ-025 Macro ALTR_HPS_RST_SEQ_HOLD_EN defined: release of stage idx is permitted only while i_stg_hold[idx]==0; cnt holds at DLY-1 while blocked.
REQ-026 Macro undefined: i_stg_hold is present but ignored; release is always permitted.

Structure
REQ-027 Package altr_hps_rst_seq_pkg holds the state encoding (S_CNT, S_DONE, S_WARM) and the CNT_WIDTH/index-width derivation function.
REQ-028 Sub-module altr_hps_rst_seq_cntr: saturating counter with sync clear, increment enable, and terminal (==DLY-1) flag, reused for S_CNT and S_WARM.

Verification
REQ-029 NUM_STG=4, DLY=8, deassert i_rst -> o_stg_rst_n = 0001/0011/0111/1111 after edges 8/16/24/32; o_seq_done rises at edge 32.
REQ-030 In S_DONE, pulse i_warm_req until ack -> o_stg_rst_n=0000 next edge, o_warm_ack high 8 edges later, full re-release 32 edges after ack.
REQ-031 i_warm_req at edge 20 (stages 0,1 released) -> all stages reasserted at edge 21, sequence restarts after o_warm_ack.
REQ-032 HOLD_EN, i_stg_hold[2]=1 for edges 0..40 -> stage 2 releases at edge 41, stage 3 at edge 49; without macro, timing per REQ-029.
REQ-033 i_rst=1 during S_WARM, cnt=5 -> all outputs zero next edge, no o_warm_ack, clean 32-edge sequence after release.
REQ-034 DLY=1, NUM_STG=3 -> stages release on edges 1,2,3; o_seq_done at edge 3; warm request with final release gives no o_seq_done.
